// File: rtl/mu0_sequencer.sv
// mu0_sequencer: fetch/execute control and register file (PC, IR, ACC) of
// the MU0 core. It drives the external ALU (X, Y, M) and takes the result Q
// back into PC or ACC. It also drives a word-addressed memory that has a
// combinational read and a write clocked on the Clk edge.
//
// Ports:
//   Clk    - rising-edge clock
//   Reset  - synchronous, active-high reset
//   X, Y   - ALU operands
//   M      - ALU function (00 Q=Y, 01 Q=X+Y, 10 Q=X+1, 11 Q=X-Y)
//   Q      - ALU result, combinational from X/Y/M
//   Addr   - memory address
//   Din    - memory read data, valid in the same cycle as Addr/Rd
//   Dout   - memory write data (always the accumulator)
//   Rd, Wr - memory strobes, never both high, both low while Reset is high
//   Halted - high while in HALT
//   Cycles - saturating count of FETCH/EXECUTE cycles since reset
module mu0_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic [DATA_W-1:0] X,
    output logic [DATA_W-1:0] Y,
    output logic [1:0]        M,
    input  logic [DATA_W-1:0] Q,
    output logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Din,
    output logic [DATA_W-1:0] Dout,
    output logic              Rd,
    output logic              Wr,
    output logic              Halted,
    output logic [15:0]       Cycles
);

    localparam int PAD_W = DATA_W - ADDR_W;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_HALT    = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [DATA_W-1:0]   ir_r;
    logic [DATA_W-1:0]   acc_r;
    logic [15:0]         cycles_r;

    logic [3:0]          opcode_s;
    logic [ADDR_W-1:0]   operand_s;
    logic                rd_s;
    logic                wr_s;
    logic                pc_load_s;
    logic                ir_load_s;
    logic                acc_load_s;

    assign opcode_s  = ir_r[DATA_W-1 -: 4];
    assign operand_s = ir_r[ADDR_W-1:0];

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: two cycles per instruction, STP parks in HALT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                state_next_s = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (opcode_s == OP_STP) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // Output decode: ALU operands, memory strobes and register load enables.
    always_comb begin
        X          = {DATA_W{1'b0}};
        Y          = {DATA_W{1'b0}};
        M          = 2'b00;
        Addr       = pc_r;
        rd_s       = 1'b0;
        wr_s       = 1'b0;
        pc_load_s  = 1'b0;
        ir_load_s  = 1'b0;
        acc_load_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                // PC increment goes through the ALU as X+1.
                rd_s      = 1'b1;
                X         = {{PAD_W{1'b0}}, pc_r};
                M         = 2'b10;
                ir_load_s = 1'b1;
                pc_load_s = 1'b1;
            end
            ST_EXECUTE: begin
                Addr = operand_s;
                case (opcode_s)
                    OP_LDA: begin
                        rd_s       = 1'b1;
                        Y          = Din;
                        M          = 2'b00;
                        acc_load_s = 1'b1;
                    end
                    OP_STA: begin
                        wr_s = 1'b1;
                    end
                    OP_ADD: begin
                        rd_s       = 1'b1;
                        X          = acc_r;
                        Y          = Din;
                        M          = 2'b01;
                        acc_load_s = 1'b1;
                    end
                    OP_SUB: begin
                        rd_s       = 1'b1;
                        X          = acc_r;
                        Y          = Din;
                        M          = 2'b11;
                        acc_load_s = 1'b1;
                    end
                    OP_JMP: begin
                        Y         = {{PAD_W{1'b0}}, operand_s};
                        pc_load_s = 1'b1;
                    end
                    OP_JGE: begin
                        // Target is presented either way; only the PC load is conditional.
                        Y         = {{PAD_W{1'b0}}, operand_s};
                        pc_load_s = ~acc_r[DATA_W-1];
                    end
                    OP_JNE: begin
                        Y         = {{PAD_W{1'b0}}, operand_s};
                        pc_load_s = (acc_r != {DATA_W{1'b0}});
                    end
                    default: begin
                        // STP and opcodes 8-15: no memory access, no register update.
                        rd_s = 1'b0;
                    end
                endcase
            end
            default: begin
                // HALT: idle values.
                rd_s = 1'b0;
            end
        endcase
    end

    // Reset masks the strobes immediately, whatever the state.
    assign Rd     = rd_s & ~Reset;
    assign Wr     = wr_s & ~Reset;
    assign Dout   = acc_r;
    assign Halted = (state_r == ST_HALT);
    assign Cycles = cycles_r;

    // Architectural registers PC, IR and ACC.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r  <= {ADDR_W{1'b0}};
            ir_r  <= {DATA_W{1'b0}};
            acc_r <= {DATA_W{1'b0}};
        end else begin
            if (ir_load_s) begin
                ir_r <= Din;
            end
            if (pc_load_s) begin
                pc_r <= Q[ADDR_W-1:0];
            end
            if (acc_load_s) begin
                acc_r <= Q;
            end
        end
    end

    // Saturating count of cycles spent fetching or executing.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cycles_r <= 16'd0;
        end else if ((state_r != ST_HALT) && (cycles_r != 16'hFFFF)) begin
            cycles_r <= cycles_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_mu0_sequencer.sv
module tb_mu0_sequencer;

    logic        Clk;
    logic        Reset;
    logic [15:0] X, Y, Q, Din, Dout;
    logic [1:0]  M;
    logic [11:0] Addr;
    logic        Rd, Wr, Halted;
    logic [15:0] Cycles;

    int checks = 0;
    int errors = 0;

    logic [15:0] prog [4096];
    logic [15:0] mem  [4096];
    logic        load = 1'b0;

    // Instruction-level reference model.
    int          m_phase;        // 0 fetch, 1 execute, 2 halted
    logic [11:0] m_pc;
    logic [15:0] m_ir, m_acc;
    int          m_cycles;
    logic [15:0] m_mem [4096];
    logic        m_valid = 1'b0;

    mu0_sequencer #(.ADDR_W(12), .DATA_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .X(X), .Y(Y), .M(M), .Q(Q),
        .Addr(Addr), .Din(Din), .Dout(Dout), .Rd(Rd), .Wr(Wr),
        .Halted(Halted), .Cycles(Cycles)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // External ALU
    always_comb begin
        case (M)
            2'b00:   Q = Y;
            2'b01:   Q = X + Y;
            2'b10:   Q = X + 16'd1;
            default: Q = X - Y;
        endcase
    end

    // Memory: combinational read, write on the clock edge
    assign Din = mem[Addr];
    always @(posedge Clk) begin
        if (load) begin
            for (int i = 0; i < 4096; i++) mem[i] <= prog[i];
        end else if (Wr) begin
            mem[Addr] <= Dout;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: advance one architectural step per clock edge
    always @(posedge Clk) begin
        logic [11:0] s;
        s = m_ir[11:0];
        if (load) begin
            for (int i = 0; i < 4096; i++) m_mem[i] <= prog[i];
        end
        if (Reset) begin
            m_phase  <= 0;
            m_pc     <= 12'd0;
            m_ir     <= 16'd0;
            m_acc    <= 16'd0;
            m_cycles <= 0;
            m_valid  <= 1'b1;
        end else if (m_valid) begin
            if (m_phase != 2 && m_cycles < 65535) m_cycles <= m_cycles + 1;
            if (m_phase == 0) begin
                m_ir    <= m_mem[m_pc];
                m_pc    <= m_pc + 12'd1;
                m_phase <= 1;
            end else if (m_phase == 1) begin
                m_phase <= 0;
                case (m_ir[15:12])
                    4'd0: m_acc <= m_mem[s];
                    4'd1: m_mem[s] <= m_acc;
                    4'd2: m_acc <= m_acc + m_mem[s];
                    4'd3: m_acc <= m_acc - m_mem[s];
                    4'd4: m_pc <= s;
                    4'd5: if (!m_acc[15]) m_pc <= s;
                    4'd6: if (m_acc != 16'd0) m_pc <= s;
                    4'd7: m_phase <= 2;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge Clk) begin
        logic [11:0] ea, s;
        logic        erd, ewr, chk_alu;
        logic [15:0] ex, ey;
        logic [1:0]  em;
        if (m_valid) begin
            s = m_ir[11:0];
            ea = m_pc; erd = 1'b0; ewr = 1'b0; ex = 16'd0; ey = 16'd0; em = 2'd0;
            chk_alu = 1'b1;
            if (m_phase == 0) begin
                erd = 1'b1; ex = {4'd0, m_pc}; em = 2'd2;
            end else if (m_phase == 1) begin
                ea = s;
                case (m_ir[15:12])
                    4'd0: begin erd = 1'b1; ey = m_mem[s]; end
                    4'd1: ewr = 1'b1;
                    4'd2: begin erd = 1'b1; ex = m_acc; ey = m_mem[s]; em = 2'd1; end
                    4'd3: begin erd = 1'b1; ex = m_acc; ey = m_mem[s]; em = 2'd3; end
                    4'd4: ey = {4'd0, s};
                    4'd5: if (!m_acc[15]) ey = {4'd0, s}; else chk_alu = 1'b0;
                    4'd6: if (m_acc != 16'd0) ey = {4'd0, s}; else chk_alu = 1'b0;
                    default: ;
                endcase
            end
            if (Reset) begin erd = 1'b0; ewr = 1'b0; end
            check("addr", {20'd0, Addr}, {20'd0, ea});
            check("rd", {31'd0, Rd}, {31'd0, erd});
            check("wr", {31'd0, Wr}, {31'd0, ewr});
            check("dout", {16'd0, Dout}, {16'd0, m_acc});
            check("halted", {31'd0, Halted}, (m_phase == 2) ? 32'd1 : 32'd0);
            check("cycles", {16'd0, Cycles}, m_cycles);
            if (chk_alu) begin
                check("x", {16'd0, X}, {16'd0, ex});
                check("y", {16'd0, Y}, {16'd0, ey});
                check("m", {30'd0, M}, {30'd0, em});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog[i] = 16'd0;
    endtask

    // One reset edge that also loads prog into memory and model
    task automatic do_reset();
        Reset = 1'b1;
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        clear_prog();
        tick(1);

        // Arithmetic program
        clear_prog();
        prog[0] = 16'h0010; prog[1] = 16'h2011; prog[2] = 16'h3012;
        prog[3] = 16'h1013; prog[4] = 16'h7000;
        prog[16'h10] = 16'h000F; prog[16'h11] = 16'hFFFF; prog[16'h12] = 16'h000F;
        do_reset();
        check("arith_reset_addr", {20'd0, Addr}, 32'h0);
        check("arith_reset_cycles", {16'd0, Cycles}, 32'h0);
        check("arith_reset_acc", {16'd0, Dout}, 32'h0);
        tick(2); check("acc_after_lda", {16'd0, Dout}, 32'h000F);
        tick(2); check("acc_after_add", {16'd0, Dout}, 32'h000E);
        tick(1);
        check("sub_x", {16'd0, X}, 32'h000E);
        check("sub_y", {16'd0, Y}, 32'h000F);
        check("sub_m", {30'd0, M}, 32'h3);
        tick(1); check("acc_after_sub", {16'd0, Dout}, 32'hFFFF);
        tick(1);
        check("sta_wr", {31'd0, Wr}, 32'h1);
        check("sta_rd", {31'd0, Rd}, 32'h0);
        check("sta_dout", {16'd0, Dout}, 32'hFFFF);
        check("sta_addr", {20'd0, Addr}, 32'h013);
        tick(2); check("not_halted_in_stp", {31'd0, Halted}, 32'h0);
        tick(1);
        check("halted", {31'd0, Halted}, 32'h1);
        check("cycles_10", {16'd0, Cycles}, 32'd10);
        check("mem_13", {16'd0, mem[12'h013]}, 32'hFFFF);
        tick(5);
        check("cycles_frozen", {16'd0, Cycles}, 32'd10);
        check("halt_rd", {31'd0, Rd}, 32'h0);

        // Reset during EXECUTE of ADD
        do_reset();
        tick(3);
        Reset = 1'b1;
        #1;
        check("rst_exec_rd", {31'd0, Rd}, 32'h0);
        check("rst_exec_wr", {31'd0, Wr}, 32'h0);
        tick(1);
        check("rst_exec_pc", {20'd0, Addr}, 32'h0);
        check("rst_exec_acc", {16'd0, Dout}, 32'h0);
        check("rst_exec_cycles", {16'd0, Cycles}, 32'h0);
        check("rst_exec_rd2", {31'd0, Rd}, 32'h0);
        Reset = 1'b0;
        #1;
        check("rst_exec_fetch", {31'd0, Rd}, 32'h1);

        // Conditional jumps
        clear_prog();
        prog[0] = 16'h0030; prog[1] = 16'h5020; prog[2] = 16'h0031; prog[3] = 16'h5020;
        prog[16'h20] = 16'h0032; prog[16'h21] = 16'h6040; prog[16'h22] = 16'h7000;
        prog[16'h40] = 16'h7000;
        prog[16'h30] = 16'h8000; prog[16'h31] = 16'h0001; prog[16'h32] = 16'h0000;
        do_reset();
        tick(4); check("jge_neg_no_jump", {20'd0, Addr}, 32'h002);
        tick(4); check("jge_pos_jump", {20'd0, Addr}, 32'h020);
        tick(4); check("jne_zero_no_jump", {20'd0, Addr}, 32'h022);
        tick(2);
        check("jumps_halted", {31'd0, Halted}, 32'h1);
        check("jumps_pc_past_stp", {20'd0, Addr}, 32'h023);
        check("jumps_cycles", {16'd0, Cycles}, 32'd14);

        // PC wrap through 0xFFF, with FETCH ALU check at PC=0x00F
        clear_prog();
        for (int i = 0; i < 15; i++) prog[i] = 16'h8ABC;
        prog[15] = 16'h4FFF;
        prog[12'hFFF] = 16'h8ABC;
        do_reset();
        tick(30);
        check("fetch_f_addr", {20'd0, Addr}, 32'h00F);
        check("fetch_f_x", {16'd0, X}, 32'h000F);
        check("fetch_f_m", {30'd0, M}, 32'h2);
        check("fetch_f_q", {16'd0, Q}, 32'h0010);
        tick(2);
        check("fetch_fff_addr", {20'd0, Addr}, 32'hFFF);
        tick(1);
        check("nop_rd", {31'd0, Rd}, 32'h0);
        check("nop_wr", {31'd0, Wr}, 32'h0);
        check("nop_addr", {20'd0, Addr}, 32'hABC);
        tick(1);
        check("wrap_pc", {20'd0, Addr}, 32'h000);
        check("wrap_acc", {16'd0, Dout}, 32'h0);

        // Randomized programs with occasional reset pulses
        for (int r = 0; r < 6; r++) begin
            clear_prog();
            for (int i = 0; i < 256; i++)
                prog[i] = {4'($urandom_range(0, 15)), 12'($urandom_range(0, 255))};
            do_reset();
            for (int c = 0; c < 300; c++) begin
                Reset = ($urandom_range(0, 49) == 0);
                tick(1);
            end
            Reset = 1'b0;
        end

        // Cycles saturation: JMP-to-self loop
        clear_prog();
        prog[0] = 16'h4000;
        do_reset();
        tick(70000);
        check("cycles_saturated", {16'd0, Cycles}, 32'hFFFF);
        check("loop_not_halted", {31'd0, Halted}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
